// File: rtl/rv_burst_src.sv
// Valid/ready burst transmitter: emits len words base, base+step, ... under
// downstream backpressure and pulses done once the final word is accepted.
module rv_burst_src #(
    parameter int wd = 4,
    parameter int cw = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [wd-1:0] base,
    input  logic [wd-1:0] step,
    input  logic [cw-1:0] len,
    output logic          busy,
    output logic          done,
    output logic [wd-1:0] dataout,
    output logic          dataout_val,
    input  logic          dataout_rdy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [cw-1:0]   remaining, remaining_n;
    logic [wd-1:0]   step_q, step_n;
    logic [wd-1:0]   dataout_n;
    logic            dataout_val_n;
    logic            busy_n;
    logic            done_n;
    logic            xfer;
    logic            last_word;

    // Data advance wraps modulo 2^wd; no saturation by design.
    function automatic logic [wd-1:0] next_word(input logic [wd-1:0] w,
                                                input logic [wd-1:0] s);
        return w + s;
    endfunction

    function automatic logic [cw-1:0] dec_count(input logic [cw-1:0] c);
        return (c == '0) ? '0 : c - cw'(1);
    endfunction

    assign xfer      = dataout_val && dataout_rdy;
    assign last_word = (remaining == cw'(1));

    always_comb begin
        state_n       = state;
        remaining_n   = remaining;
        step_n        = step_q;
        dataout_n     = dataout;
        dataout_val_n = dataout_val;
        busy_n        = busy;
        done_n        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    step_n = step;
                    if (len != '0) begin
                        dataout_n     = base;
                        dataout_val_n = 1'b1;
                        busy_n        = 1'b1;
                        remaining_n   = len;
                        state_n       = SEND;
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            SEND: begin
                // Without a transfer every output holds, so valid cannot drop early.
                if (xfer) begin
                    if (last_word) begin
                        dataout_val_n = 1'b0;
                        busy_n        = 1'b0;
                        done_n        = 1'b1;
                        remaining_n   = '0;
                        state_n       = IDLE;
                    end else begin
                        remaining_n = dec_count(remaining);
                        dataout_n   = next_word(dataout, step_q);
                    end
                end
            end
            default: begin
                state_n       = IDLE;
                dataout_val_n = 1'b0;
                busy_n        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            remaining   <= '0;
            step_q      <= '0;
            dataout     <= '0;
            dataout_val <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            remaining   <= remaining_n;
            step_q      <= step_n;
            dataout     <= dataout_n;
            dataout_val <= dataout_val_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end

endmodule

// File: tb/tb_rv_burst_src.sv
// Directed bench for rv_burst_src: stimulus pushes expected words and done
// markers into a queue; a negedge monitor pops them as the DUT produces them.
module tb_rv_burst_src;

    localparam int WD        = 4;
    localparam int CW        = 4;
    localparam int DONE_MARK = -1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WD-1:0] base;
    logic [WD-1:0] step;
    logic [CW-1:0] len;
    logic          busy;
    logic          done;
    logic [WD-1:0] dataout;
    logic          dataout_val;
    logic          dataout_rdy;

    int sb[$];
    int checks = 0;
    int errors = 0;

    rv_burst_src #(.wd(WD), .cw(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base        (base),
        .step        (step),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .dataout     (dataout),
        .dataout_val (dataout_val),
        .dataout_rdy (dataout_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [WD-1:0] b, input logic [WD-1:0] s,
                         input logic [CW-1:0] l);
        start = 1'b1;
        base  = b;
        step  = s;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, int'(done), 1);
        tick();
        check({name, "_done_pulse_end"}, int'(done), 0);
    endtask

    // Monitor: sample mid-cycle, where outputs and ready are what the next edge sees.
    logic          prev_stall = 1'b0;
    logic [WD-1:0] prev_data  = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_val", int'(dataout_val), 1);
                check("stall_hold_data", int'(dataout), int'(prev_data));
            end
            if (dataout_val && dataout_rdy) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", int'(dataout), -100);
                end else begin
                    check("word", int'(dataout), sb.pop_front());
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("done_order", DONE_MARK, sb.pop_front());
                end
            end
            prev_stall = dataout_val && !dataout_rdy;
            prev_data  = dataout;
        end
    end

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        base        = '0;
        step        = '0;
        len         = '0;
        dataout_rdy = 1'b0;
        tick();
        tick();
        check("rst_val", int'(dataout_val), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_data", int'(dataout), 0);
        rst = 1'b0;
        tick();

        // Reset mid-burst: asynchronous clear, no done afterwards.
        issue(4'd3, 4'd1, 4'd5);
        check("pre_rst_val", int'(dataout_val), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_val", int'(dataout_val), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_data", int'(dataout), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_done", int'(done), 0);

        // Streaming 5,6,7.
        dataout_rdy = 1'b1;
        sb.push_back(5); sb.push_back(6); sb.push_back(7); sb.push_back(DONE_MARK);
        issue(4'd5, 4'd1, 4'd3);
        check("s_first", int'(dataout), 5);
        check("s_busy", int'(busy), 1);
        tick();
        check("s_second", int'(dataout), 6);
        tick();
        check("s_third", int'(dataout), 7);
        tick();
        check("s_done", int'(done), 1);
        check("s_val_low", int'(dataout_val), 0);
        check("s_hold_last", int'(dataout), 7);
        check("s_busy_low", int'(busy), 0);
        tick();
        check("s_done_once", int'(done), 0);
        check("s_hold_last2", int'(dataout), 7);

        // Backpressure with wrap: 15 then 0.
        dataout_rdy = 1'b0;
        sb.push_back(15); sb.push_back(0); sb.push_back(DONE_MARK);
        issue(4'd15, 4'd1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_data", int'(dataout), 15);
            check("bp_stall_val", int'(dataout_val), 1);
            if (i < 2) tick();
        end
        dataout_rdy = 1'b1;
        wait_done("bp", 10);

        // Empty burst.
        sb.push_back(DONE_MARK);
        issue(4'd8, 4'd1, 4'd0);
        check("e_done", int'(done), 1);
        check("e_val", int'(dataout_val), 0);
        check("e_busy", int'(busy), 0);
        tick();
        check("e_done_once", int'(done), 0);
        check("e_val2", int'(dataout_val), 0);

        // Alternating ready: 14, 1, 4.
        dataout_rdy = 1'b0;
        sb.push_back(14); sb.push_back(1); sb.push_back(4); sb.push_back(DONE_MARK);
        issue(4'd14, 4'd3, 4'd3);
        begin
            int n = 0;
            while (!done && n < 20) begin
                dataout_rdy = ~dataout_rdy;
                tick();
                n++;
            end
        end
        check("alt_done_seen", int'(done), 1);
        dataout_rdy = 1'b1;
        tick();
        check("alt_done_once", int'(done), 0);

        // Start during a burst is ignored; start in the done cycle is taken.
        sb.push_back(2); sb.push_back(4); sb.push_back(6); sb.push_back(DONE_MARK);
        sb.push_back(9); sb.push_back(DONE_MARK);
        issue(4'd2, 4'd2, 4'd3);
        start = 1'b1; base = 4'd9; step = 4'd0; len = 4'd1;
        tick();
        start = 1'b0;
        check("c_ignored", int'(dataout), 4);
        tick();
        check("c_third", int'(dataout), 6);
        tick();
        check("c_done", int'(done), 1);
        start = 1'b1; base = 4'd9; step = 4'd0; len = 4'd1;
        tick();
        start = 1'b0;
        check("c_new_data", int'(dataout), 9);
        check("c_new_val", int'(dataout_val), 1);
        check("c_new_done_low", int'(done), 0);
        tick();
        check("c_new_done", int'(done), 1);
        tick();
        tick();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
